// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module  : systolic_pe
// Brief   : Systolic-array MAC cell, output-stationary or weight-stationary.
// Revision: 1.0 - initial release
// ============================================================================
module systolic_pe #(
    parameter int IN_W     = 8,
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic                    mode,
    input  logic signed [IN_W-1:0]  in_a,
    input  logic signed [IN_W-1:0]  in_b,
    input  logic                    in_vld,
    input  logic                    in_last,
    input  logic                    w_load,
    input  logic signed [ACC_W-1:0] in_psum,
    output logic signed [IN_W-1:0]  out_a,
    output logic signed [IN_W-1:0]  out_b,
    output logic                    out_vld,
    output logic                    out_last,
    output logic signed [ACC_W-1:0] out_c,
    output logic                    out_c_vld,
    output logic                    ovf
);

    localparam int                     c_PROD_W  = 2 * IN_W;
    localparam int                     c_EXT_W   = ACC_W + 1 - c_PROD_W;
    localparam logic signed [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                    r_mode;
    logic signed [IN_W-1:0]  r_weight;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [IN_W-1:0]  r_out_a;
    logic signed [IN_W-1:0]  r_out_b;
    logic                    r_out_vld;
    logic                    r_out_last;
    logic signed [ACC_W-1:0] r_out_c;
    logic                    r_out_c_vld;
    logic                    r_ovf;

    logic signed [c_PROD_W-1:0] w_op_a;
    logic signed [c_PROD_W-1:0] w_op_b;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W:0]      w_prod_ext;
    logic signed [ACC_W:0]      w_addend;
    logic signed [ACC_W:0]      w_sum;
    logic                       w_ovf_hit;
    logic signed [ACC_W-1:0]    w_sat;
    logic                       w_mode_chg;

    // Operands are widened first so the product is exact in 2*IN_W bits.
    assign w_op_a = {{IN_W{in_a[IN_W-1]}}, in_a};
    assign w_op_b = r_mode ? {{IN_W{r_weight[IN_W-1]}}, r_weight}
                           : {{IN_W{in_b[IN_W-1]}}, in_b};
    assign w_prod = w_op_a * w_op_b;

    assign w_prod_ext = {{c_EXT_W{w_prod[c_PROD_W-1]}}, w_prod};
    assign w_addend   = r_mode ? {in_psum[ACC_W-1], in_psum}
                               : {r_acc[ACC_W-1], r_acc};
    assign w_sum      = w_addend + w_prod_ext;

    // The ACC_W+1 sum leaves the ACC_W range exactly when its top two bits differ.
    assign w_ovf_hit  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_mode_chg = (mode != r_mode);

    always_comb begin
        w_sat = w_sum[ACC_W-1:0];
        if (w_ovf_hit && SATURATE) begin
            w_sat = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= 1'b0;
            r_weight    <= '0;
            r_acc       <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_c     <= '0;
            r_out_c_vld <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (enb) begin
            r_out_a    <= in_a;
            r_out_b    <= in_b;
            r_out_vld  <= in_vld;
            r_out_last <= in_last;

            if (w_mode_chg) begin
                // Switching dataflow discards all arithmetic state; this cycle's beat is dropped.
                r_mode      <= mode;
                r_weight    <= '0;
                r_acc       <= '0;
                r_out_c     <= '0;
                r_out_c_vld <= 1'b0;
                r_ovf       <= 1'b0;
            end else if (!r_mode) begin
                if (in_vld) begin
                    r_ovf <= r_ovf | w_ovf_hit;
                    if (in_last) begin
                        r_out_c     <= w_sat;
                        r_out_c_vld <= 1'b1;
                        r_acc       <= '0;
                    end else begin
                        r_acc       <= w_sat;
                        r_out_c_vld <= 1'b0;
                    end
                end else begin
                    r_out_c_vld <= 1'b0;
                end
            end else begin
                // The product above already used the old weight, so a same-cycle load is safe.
                if (w_load) begin
                    r_weight <= in_b;
                end
                if (in_vld) begin
                    r_out_c <= w_sat;
                    r_ovf   <= r_ovf | w_ovf_hit;
                end
                r_out_c_vld <= in_vld;
            end
        end
    end

    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_vld   = r_out_vld;
    assign out_last  = r_out_last;
    assign out_c     = r_out_c;
    assign out_c_vld = r_out_c_vld;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_pe
// Brief   : Self-checking bench for systolic_pe, three parameterisations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_pe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enb, mode, in_vld, in_last, w_load;
    logic signed [7:0]  in_a, in_b;
    logic signed [23:0] in_psum;

    logic signed [7:0]  out_a0, out_b0, out_a1, out_b1, out_a2, out_b2;
    logic               out_vld0, out_last0, out_vld1, out_last1, out_vld2, out_last2;
    logic signed [23:0] out_c0;
    logic signed [15:0] out_c1, out_c2;
    logic               out_c_vld0, out_c_vld1, out_c_vld2, ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    systolic_pe #(.IN_W(8), .ACC_W(24), .SATURATE(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .in_a(in_a), .in_b(in_b),
        .in_vld(in_vld), .in_last(in_last), .w_load(w_load), .in_psum(in_psum),
        .out_a(out_a0), .out_b(out_b0), .out_vld(out_vld0), .out_last(out_last0),
        .out_c(out_c0), .out_c_vld(out_c_vld0), .ovf(ovf0));

    systolic_pe #(.IN_W(8), .ACC_W(16), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .in_a(in_a), .in_b(in_b),
        .in_vld(in_vld), .in_last(in_last), .w_load(w_load), .in_psum(in_psum[15:0]),
        .out_a(out_a1), .out_b(out_b1), .out_vld(out_vld1), .out_last(out_last1),
        .out_c(out_c1), .out_c_vld(out_c_vld1), .ovf(ovf1));

    systolic_pe #(.IN_W(8), .ACC_W(16), .SATURATE(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .in_a(in_a), .in_b(in_b),
        .in_vld(in_vld), .in_last(in_last), .w_load(w_load), .in_psum(in_psum[15:0]),
        .out_a(out_a2), .out_b(out_b2), .out_vld(out_vld2), .out_last(out_last2),
        .out_c(out_c2), .out_c_vld(out_c_vld2), .ovf(ovf2));

    logic [43:0] obs [3];
    assign obs[0] = {out_a0, out_b0, out_vld0, out_last0, out_c0, out_c_vld0, ovf0};
    assign obs[1] = {out_a1, out_b1, out_vld1, out_last1, 8'h00, out_c1, out_c_vld1, ovf1};
    assign obs[2] = {out_a2, out_b2, out_vld2, out_last2, 8'h00, out_c2, out_c_vld2, ovf2};

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: arithmetic kept as plain integers.
    int         aw [3];
    bit         satf [3];
    bit         m_mode, m_ocv, m_ov, m_ol;
    longint     m_w;
    longint     m_acc [3];
    longint     m_oc [3];
    bit         m_ovf [3];
    logic [7:0] m_oa, m_ob;

    function automatic longint wrapw(longint v, int w);
        longint m, h, r;
        m = longint'(1) << w;
        h = longint'(1) << (w - 1);
        r = (v + h) % m;
        if (r < 0) r += m;
        return r - h;
    endfunction

    function automatic longint satv(longint s, int k, output bit hit);
        longint mx, mn;
        mx  = (longint'(1) << (aw[k] - 1)) - 1;
        mn  = -(longint'(1) << (aw[k] - 1));
        hit = (s > mx) || (s < mn);
        if (!hit) return s;
        if (satf[k]) return (s > mx) ? mx : mn;
        return wrapw(s, aw[k]);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ocv = 0; m_ov = 0; m_ol = 0; m_w = 0; m_oa = '0; m_ob = '0;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_oc[k] = 0; m_ovf[k] = 0;
        end
    endtask

    task automatic model_step();
        bit     hit;
        longint a, b, old_w, r;
        if (!enb) return;
        a = longint'(in_a);
        b = longint'(in_b);
        m_oa = in_a; m_ob = in_b; m_ov = in_vld; m_ol = in_last;
        if (mode != m_mode) begin
            m_mode = mode; m_w = 0; m_ocv = 0;
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0; m_oc[k] = 0; m_ovf[k] = 0;
            end
        end else if (!m_mode) begin
            if (in_vld) begin
                for (int k = 0; k < 3; k++) begin
                    r = satv(m_acc[k] + a * b, k, hit);
                    if (hit) m_ovf[k] = 1;
                    if (in_last) begin
                        m_oc[k] = r; m_acc[k] = 0;
                    end else begin
                        m_acc[k] = r;
                    end
                end
            end
            m_ocv = in_vld && in_last;
        end else begin
            old_w = m_w;
            if (w_load) m_w = b;
            if (in_vld) begin
                for (int k = 0; k < 3; k++) begin
                    m_oc[k] = satv(wrapw(longint'(in_psum), aw[k]) + a * old_w, k, hit);
                    if (hit) m_ovf[k] = 1;
                end
            end
            m_ocv = in_vld;
        end
    endtask

    function automatic logic [43:0] exp_vec(int k);
        logic [23:0] oc;
        longint      v;
        v  = m_oc[k];
        oc = (aw[k] == 24) ? v[23:0] : {8'h00, v[15:0]};
        return {m_oa, m_ob, m_ov, m_ol, oc, m_ocv, m_ovf[k]};
    endfunction

    task automatic drive(input logic e, input logic md, input int a, input int b,
                         input logic v, input logic l, input logic wl, input int ps);
        enb = e; mode = md; in_a = 8'(a); in_b = 8'(b);
        in_vld = v; in_last = l; w_load = wl; in_psum = 24'(ps);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL reset dut%0d got %h want %h", k, obs[k], exp_vec(k));
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_os_dot();
        int a [5] = '{3, -2, 7, 0, 2};
        int b [5] = '{4, 5, 1, 0, 3};
        bit v [5] = '{1, 1, 1, 0, 1};
        bit l [5] = '{0, 0, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, a[i], b[i], v[i], l[i], 0, 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL os_dot[%0d] dut%0d got %h want %h", i, k, obs[k], exp_vec(k));
                end
            end
            if (i == 2) begin
                vectors++;
                if (out_c0 !== 24'sd9 || out_c_vld0 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL os_dot_result got c=%0d v=%b want c=9 v=1", out_c0, out_c_vld0);
                end
            end else if (i == 3) begin
                vectors++;
                if (out_c0 !== 24'sd9 || out_c_vld0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL os_dot_pulse got c=%0d v=%b want c=9 v=0", out_c0, out_c_vld0);
                end
            end else if (i == 4) begin
                vectors++;
                if (out_c0 !== 24'sd6) begin
                    miscompares++;
                    $display("FAIL os_dot_restart got %0d want 6", out_c0);
                end
            end
        end
    endtask

    task automatic test_os_overflow();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 127, 127, i < 5, i == 4, 0, 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL os_ovf[%0d] dut%0d got %h want %h", i, k, obs[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if (out_c1 !== 16'sd32767 || ovf1 !== 1'b1 || out_c2 !== 16'sd15109 || ovf2 !== 1'b1
            || out_c0 !== 24'sd80645 || ovf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL os_ovf_final got sat=%0d/%b wrap=%0d/%b wide=%0d/%b want 32767/1 15109/1 80645/0",
                     out_c1, ovf1, out_c2, ovf2, out_c0, ovf0);
        end
    endtask

    task automatic test_mode_change();
        drive(1, 0, 5, 10, 1, 0, 0, 0);
        tick();
        drive(1, 1, 3, 9, 1, 1, 1, 7);
        tick();
        vectors++;
        if (out_c_vld0 !== 1'b0 || out_c0 !== 24'sd0 || ovf1 !== 1'b0 || ovf2 !== 1'b0
            || out_a0 !== 8'sd3 || out_b0 !== 8'sd9) begin
            miscompares++;
            $display("FAIL mode_change got v=%b c=%0d ovf=%b%b a=%0d b=%0d want 0 0 00 3 9",
                     out_c_vld0, out_c0, ovf1, ovf2, out_a0, out_b0);
        end
        drive(1, 1, 4, 0, 1, 0, 0, 7);
        tick();
        vectors++;
        if (out_c0 !== 24'sd7 || out_c_vld0 !== 1'b1) begin
            miscompares++;
            $display("FAIL mode_change_weight got c=%0d v=%b want 7 1", out_c0, out_c_vld0);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL mode_change dut%0d got %h want %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_ws();
        int a  [5] = '{0, 4, 2, 1, 0};
        int b  [5] = '{-3, 0, 5, 0, 0};
        bit v  [5] = '{0, 1, 1, 1, 0};
        bit wl [5] = '{1, 0, 1, 0, 0};
        int ps [5] = '{0, 100, 0, 10, 0};
        int ec [5] = '{7, 88, -6, 15, 15};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, a[i], b[i], v[i], 1, wl[i], ps[i]);
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL ws[%0d] dut%0d got %h want %h", i, k, obs[k], exp_vec(k));
                end
            end
            vectors++;
            if (out_c0 !== 24'(ec[i]) || out_c_vld0 !== v[i]) begin
                miscompares++;
                $display("FAIL ws_result[%0d] got c=%0d v=%b want c=%0d v=%b", i, out_c0, out_c_vld0, ec[i], v[i]);
            end
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 0, 0, 0, 0, 0);  tick();
        drive(1, 0, 6, 7, 1, 0, 0, 0);  tick();
        drive(1, 0, 1, 2, 1, 1, 0, 0);  tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom), int'($urandom), int'($urandom), 1, 1, 1, int'($urandom));
            tick();
            vectors++;
            if (out_c_vld0 !== 1'b1 || out_c0 !== 24'sd44 || out_a0 !== 8'sd1 || out_b0 !== 8'sd2) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got v=%b c=%0d a=%0d b=%0d want 1 44 1 2",
                         i, out_c_vld0, out_c0, out_a0, out_b0);
            end
        end
        drive(1, 0, 2, 3, 1, 0, 0, 0);  tick();
        vectors++;
        if (out_c_vld0 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release got v=%b want 0", out_c_vld0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'($urandom), int'($urandom), int'($urandom), 1, 1, 0, 0);
            tick();
        end
        drive(1, 0, 1, 1, 1, 1, 0, 0);  tick();
        vectors++;
        if (out_c0 !== 24'sd7 || out_c_vld0 !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_acc_frozen got c=%0d v=%b want 7 1", out_c0, out_c_vld0);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL stall dut%0d got %h want %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        logic md;
        int   ps;
        md = mode;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) md = ~md;
            case ($urandom_range(0, 2))
                0:       ps = int'($urandom_range(0, 400)) - 200;
                1:       ps = int'($urandom);
                default: ps = ($urandom_range(0, 1) == 1) ? 8388607 - int'($urandom_range(0, 30000))
                                                          : -8388608 + int'($urandom_range(0, 30000));
            endcase
            drive($urandom_range(0, 7) != 0, md, int'($urandom), int'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, ps);
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random[%0d] dut%0d got %h want %h", i, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);  tick();
        drive(1, 0, 10, 10, 1, 0, 0, 0); tick();
        tick();
        enb = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL async_reset dut%0d got %h want %h", k, obs[k], exp_vec(k));
            end
        end
        drive(1, 0, 3, 3, 1, 1, 0, 0);
        #2;
        rst = 1'b1;
        tick();
        vectors++;
        if (out_c0 !== 24'sd9 || out_c_vld0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_restart got c=%0d v=%b want 9 1", out_c0, out_c_vld0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        aw[0] = 24; aw[1] = 16; aw[2] = 16;
        satf[0] = 1; satf[1] = 1; satf[2] = 0;
        test_reset();
        test_os_dot();
        test_os_overflow();
        test_mode_change();
        test_ws();
        test_stall();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
